// File: rtl/axil_reg_slave_if.sv
// AXI-Lite link bundle. The m_axil modport is the register-slave end of
// the link; s_axil is the requesting end.
interface axil_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport m_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register-file slave: NUM_RW byte-writable control registers
// (each with a one-cycle update strobe) followed by NUM_RO read-only status
// words. Anything outside the decoded window, or a write to a status word,
// completes with SLVERR so the link never stalls.
module axil_reg_slave #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = {AXI_ADDR_WIDTH{1'b0}},
    parameter int                        NUM_RW         = 8,
    parameter int                        NUM_RO         = 4
) (
    input  logic                                                 aclk,
    input  logic                                                 areset,
    axil_if.m_axil                                               axil,
    output logic [NUM_RW*AXI_DATA_WIDTH-1:0]                     reg_out,
    output logic [NUM_RW-1:0]                                    reg_wr_pulse,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*AXI_DATA_WIDTH-1:0]  status_in
);

    localparam int DW       = AXI_DATA_WIDTH;
    localparam int AW       = AXI_ADDR_WIDTH;
    localparam int BYTES    = DW / 8;
    localparam int LSB      = $clog2(BYTES);
    localparam int NUM_REGS = NUM_RW + NUM_RO;
    // A single-register bank still needs a one-bit index field.
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TAG_LSB  = IDX_W + LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Window hit: every address bit above the index field matches the base.
    function automatic logic f_hit(input logic [AW-1:0] addr);
        return (addr[AW-1:TAG_LSB] == BASE_ADDR[AW-1:TAG_LSB]);
    endfunction

    // Byte-lane merge: lanes with a set strobe take the new byte.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0]    old_v,
                                              input logic [DW-1:0]    new_v,
                                              input logic [BYTES-1:0] strb);
        logic [DW-1:0] v;
        v = old_v;
        for (int k = 0; k < BYTES; k++) begin
            v[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return v;
    endfunction

    logic                  r_aw_held;
    logic [AW-1:0]         r_awaddr;
    logic                  r_w_held;
    logic [DW-1:0]         r_wdata;
    logic [BYTES-1:0]      r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DW-1:0]         r_rdata;
    logic [1:0]            r_rresp;
    logic [NUM_RW*DW-1:0]  r_regs;
    logic [NUM_RW-1:0]     r_wr_pulse;

    logic                  w_commit;
    logic [IDX_W-1:0]      w_widx;
    logic                  w_wr_ok;
    logic [1:0]            w_wresp;
    logic [NUM_RW-1:0]     w_wr_sel;
    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_ridx;
    logic [DW-1:0]         w_rdata;
    logic [1:0]            w_rresp;
    logic                  w_unused_addr;

    // Readies come straight from the holding flags, never from the valids.
    assign axil.awready = ~r_aw_held;
    assign axil.wready  = ~r_w_held;
    assign axil.arready = ~r_rvalid;
    assign axil.bvalid  = r_bvalid;
    assign axil.bresp   = r_bresp;
    assign axil.rvalid  = r_rvalid;
    assign axil.rdata   = r_rdata;
    assign axil.rresp   = r_rresp;
    assign reg_out      = r_regs;
    assign reg_wr_pulse = r_wr_pulse;

    // Sub-word address bits carry no meaning for a word-wide register file.
    assign w_unused_addr = ^{r_awaddr[LSB-1:0], axil.araddr[LSB-1:0]};

    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;
    assign w_ar_hs  = axil.arvalid & ~r_rvalid;

    // Decode the held write: target control-register select and response.
    always_comb begin
        w_widx  = r_awaddr[LSB +: IDX_W];
        w_wr_ok = f_hit(r_awaddr) && (int'(w_widx) < NUM_RW);
        if (w_wr_ok) begin
            w_wresp = RESP_OKAY;
        end else begin
            w_wresp = RESP_SLVERR;
        end
        for (int i = 0; i < NUM_RW; i++) begin
            w_wr_sel[i] = w_commit && w_wr_ok && (int'(w_widx) == i);
        end
    end

    // Decode the incoming read address into the word to return.
    always_comb begin
        w_ridx  = axil.araddr[LSB +: IDX_W];
        w_rdata = {DW{1'b0}};
        w_rresp = RESP_SLVERR;
        if (f_hit(axil.araddr)) begin
            for (int i = 0; i < NUM_RW; i++) begin
                w_rdata = (int'(w_ridx) == i) ? r_regs[i*DW +: DW] : w_rdata;
                w_rresp = (int'(w_ridx) == i) ? RESP_OKAY : w_rresp;
            end
            for (int j = 0; j < NUM_RO; j++) begin
                w_rdata = (int'(w_ridx) == NUM_RW + j) ? status_in[j*DW +: DW] : w_rdata;
                w_rresp = (int'(w_ridx) == NUM_RW + j) ? RESP_OKAY : w_rresp;
            end
        end else begin
            w_rdata = {DW{1'b0}};
            w_rresp = RESP_SLVERR;
        end
    end

    // AW/W one-deep holding buffers and the B response channel.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= {AW{1'b0}};
            r_w_held  <= 1'b0;
            r_wdata   <= {DW{1'b0}};
            r_wstrb   <= {BYTES{1'b0}};
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wresp;
        end else begin
            if (axil.awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= axil.awaddr;
            end
            if (axil.wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= axil.wdata;
                r_wstrb  <= axil.wstrb;
            end
            if (r_bvalid && axil.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Control registers and their update strobes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_regs     <= {(NUM_RW*DW){1'b0}};
            r_wr_pulse <= {NUM_RW{1'b0}};
        end else begin
            r_wr_pulse <= w_wr_sel;
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i*DW +: DW] <= f_merge(r_regs[i*DW +: DW], r_wdata, r_wstrb);
                end
            end
        end
    end

    // R channel: capture data on AR acceptance, hold until the R handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= {DW{1'b0}};
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rresp;
        end else if (r_rvalid && axil.rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule
